// File: rtl/qsys_timer_sequencer.sv
// qsys_timer_sequencer: steps the system interval timer through a table of up
// to four 32-bit periods without CPU help. The host programs the table and
// control over a 16-bit Avalon-MM slave. A 16-bit Avalon-MM master writes the
// timer registers: 0 status, 1 control, 2 period_l, 3 period_h.
// Optional feature macro: TIMER_SEQ_IRQ_EN drives irq = done & IE, registered.
// Without it, irq is tied 0 and CTRL.IE is not stored.
module qsys_timer_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq,
    output logic        step_pulse,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_WR_PL, S_WR_PH, S_CLR, S_START, S_WAIT, S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [3:0][31:0]  tbl_q;
    logic              loop_q;
    logic [1:0]        last_q;
    logic [1:0]        idx_q;
    logic              done_q, aborted_q, abort_q;
    logic [15:0]       stepcnt_q;
    logic              abort_set;
    logic              ie_rd;
    logic [15:0]       rd_d;
    logic [31:0]       cur_entry, load_val;

    wire host_wr   = chipselect & ~write_n;
    wire ctrl_wr   = host_wr & (address == 4'd0);
    wire status_wr = host_wr & (address == 4'd1);
    // STOP wins over GO when both are set in the same write.
    wire stop_cmd  = ctrl_wr & writedata[2];
    wire go_cmd    = ctrl_wr & writedata[0] & ~writedata[2];
    wire busy      = (state_q != S_IDLE);
    wire start     = go_cmd & ~busy;

    // A zero period would never time out cleanly, so zero is sent as 1.
    assign cur_entry = tbl_q[idx_q];
    assign load_val  = (cur_entry == 32'd0) ? 32'd1 : cur_entry;

`ifdef TIMER_SEQ_IRQ_EN
    logic ie_q, irq_q;
    assign ie_rd = ie_q;
    assign irq   = irq_q;

    // Store IE and drive the done interrupt. A STATUS write drops irq at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= writedata[3];
            irq_q <= status_wr ? 1'b0 : (done_q & ie_q);
        end
    end
`else
    assign ie_rd = 1'b0;
    assign irq   = 1'b0;
`endif

    // Next state. A STOP while busy ends the current single-cycle write and
    // then redirects to HALT. The abort path then returns to IDLE.
    always_comb begin
        state_d   = state_q;
        abort_set = 1'b0;
        case (state_q)
            S_IDLE:  if (go_cmd) state_d = S_HALT;
            S_HALT:  state_d = abort_q ? S_IDLE : S_WR_PL;
            S_WR_PL: state_d = S_WR_PH;
            S_WR_PH: state_d = S_CLR;
            S_CLR:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (tmr_irq) state_d = S_ACK;
            S_ACK:   state_d = (idx_q == last_q && !loop_q) ? S_IDLE : S_WR_PL;
            default: state_d = S_IDLE;
        endcase
        if (busy && stop_cmd && !(state_q == S_HALT && abort_q)) begin
            state_d   = S_HALT;
            abort_set = 1'b1;
        end
    end

    // Timer-side bus. Every state except IDLE and WAIT issues exactly one write.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        step_pulse     = 1'b0;
        if (state_q != S_IDLE && state_q != S_WAIT) begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
        end
        case (state_q)
            S_HALT:  begin tmr_address = 3'd1; tmr_writedata = 16'h0008; end
            S_WR_PL: begin tmr_address = 3'd2; tmr_writedata = load_val[15:0]; end
            S_WR_PH: begin tmr_address = 3'd3; tmr_writedata = load_val[31:16]; end
            S_CLR:   tmr_address = 3'd0;
            S_START: begin tmr_address = 3'd1; tmr_writedata = 16'h0005; end
            S_ACK:   step_pulse = 1'b1;
            default: ;
        endcase
    end

    // FSM state register and the abort-in-progress flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (abort_set)              abort_q <= 1'b1;
            else if (state_q == S_HALT) abort_q <= 1'b0;
        end
    end

    // Host-visible registers: control, table, status flags, index and step count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_q     <= '0;
            loop_q    <= 1'b0;
            last_q    <= 2'd0;
            idx_q     <= 2'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            stepcnt_q <= 16'd0;
        end else begin
            if (ctrl_wr) begin
                loop_q <= writedata[1];
                last_q <= writedata[5:4];
            end
            if (host_wr && address[3]) begin
                if (address[0]) tbl_q[address[2:1]][31:16] <= writedata;
                else            tbl_q[address[2:1]][15:0]  <= writedata;
            end
            if (status_wr) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
            if (start) begin
                idx_q     <= 2'd0;
                stepcnt_q <= 16'd0;
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
            if (state_q == S_ACK) begin
                stepcnt_q <= stepcnt_q + 16'd1;
                if (state_d == S_IDLE) done_q <= 1'b1;
                if (state_d == S_WR_PL) idx_q <= (idx_q == last_q) ? 2'd0 : idx_q + 2'd1;
            end
            if (state_q == S_HALT && abort_q) aborted_q <= 1'b1;
        end
    end

    // Host read mux. The value is registered, so it shows state as of the address cycle.
    always_comb begin
        rd_d = 16'h0000;
        case (address)
            4'd0: rd_d = {10'd0, last_q, ie_rd, 1'b0, loop_q, 1'b0};
            4'd1: rd_d = {10'd0, idx_q, 1'b0, aborted_q, done_q, busy};
            4'd2: rd_d = stepcnt_q;
            default: begin
                if (address[3])
                    rd_d = address[0] ? tbl_q[address[2:1]][31:16] : tbl_q[address[2:1]][15:0];
            end
        endcase
    end

    // Read data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 16'h0000;
        else          readdata <= rd_d;
    end

endmodule

// File: doc/qsys_timer_sequencer.md
# qsys_timer_sequencer

Hardware sequencer that drives the system interval timer through a programmable list of up to four 32-bit periods, with no CPU involvement between steps. Host side: a 16-bit Avalon-MM slave holding the period table and control. Timer side: a 16-bit Avalon-MM master that writes the timer's register map (0 status, 1 control, 2 period_l, 3 period_h) and consumes the timer's `irq`. Emits a one-cycle `step_pulse` per completed period.

## Interface
- No parameters. Table depth is fixed at 4 entries; data width is fixed at 16.
- `clk`  in  1  single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  in  4  host register select
- `chipselect`  in  1  host select
- `write_n`  in  1  host write, active low
- `writedata`  in  16  host write data
- `readdata`  out  16  host read data, registered
- `tmr_address`  out  3  timer register select
- `tmr_chipselect`  out  1  timer select
- `tmr_write_n`  out  1  timer write, active low
- `tmr_writedata`  out  16  timer write data
- `tmr_irq`  in  1  timer timeout interrupt (TO & ITO)
- `step_pulse`  out  1  one cycle per period completed
- `irq`  out  1  sequence-done interrupt (see Configuration)

## Operation
- Host map:
  - 0 CTRL (R/W): bit0 GO (write-1 strobe, reads 0), bit1 LOOP, bit2 STOP (write-1 strobe, reads 0), bit3 IE, bits[5:4] LAST (index of the final entry).
  - 1 STATUS: read {busy[0], done[1], aborted[2], idx[5:4]}. Any write clears done and aborted.
  - 2 STEPCNT: read-only 16-bit count of step pulses; wraps 0xFFFF→0; cleared on GO.
  - 8+2i / 9+2i: entry i low/high halfwords (R/W).
  - Unmapped addresses read 0.
- FSM states: IDLE, HALT, WR_PL, WR_PH, CLR, START, WAIT, ACK. Every non-IDLE/WAIT state issues exactly one timer write, then advances.
  - IDLE: on GO, set busy, idx=0, STEPCNT=0, clear done/aborted → HALT.
  - HALT: write ctrl=0x0008 (STOP, ITO off) → WR_PL. When entered via abort → IDLE instead.
  - WR_PL, WR_PH: write entry[idx] halves. An entry value of 0 is sent as 1 (minimum period).
  - CLR: write status=0.
  - START: write ctrl=0x0005 (START|ITO, non-continuous) → WAIT.
  - WAIT: no timer access; on `tmr_irq`=1 → ACK.
  - ACK: write status=0; pulse `step_pulse`; STEPCNT++.
    - If idx==LAST and !LOOP: clear busy, set done → IDLE.
    - Else idx = (idx==LAST) ? 0 : idx+1 → WR_PL.
- STOP (or GO+STOP in the same write; STOP wins) while busy: at the next state boundary (the current single-cycle write completes), go to HALT; the abort path returns to IDLE with busy=0 and aborted=1. STOP in IDLE: no effect.
- GO while busy: ignored. LOOP/LAST/IE and table writes while busy are accepted; a table write takes effect the next time that entry is loaded.

## Timing
- Reset: all outputs 0, except `tmr_write_n`=1. FSM=IDLE; table, CTRL, STATUS, STEPCNT all 0.
- Timer writes: single cycle (`tmr_chipselect`=1, `tmr_write_n`=0), back-to-back, no waitrequest.
- GO write cycle N: HALT write in N+1, WR_PL N+2, WR_PH N+3, CLR N+4, START N+5, WAIT from N+6.
- `tmr_irq` seen high in cycle M: ACK write and `step_pulse` in M+1; next WR_PL in M+2.
- Host `readdata` valid the cycle after the read address; it reflects state as of the address cycle.
- `tmr_irq` is sampled only in WAIT. No spurious re-entry: the CLR write precedes START.

## Configuration
- `TIMER_SEQ_IRQ_EN` defined: `irq` = done & IE, registered; cleared by a STATUS write.
- Not defined: `irq` is tied 0; CTRL bit3 reads 0 and is not stored.

## Test plan
- Reset, then read all registers: all 0, `tmr_write_n`=1, `irq`=0.
- Table {100, 0x0001_0000}, LAST=1, GO, model timer: write order exactly 0x0008, 100, 0, 0, 0x0005 (each to its register); two step pulses; done=1, STEPCNT=2.
- LOOP=1, LAST=0, entry0=5: ≥10 steps, idx stays 0. Then STOP mid-WAIT: HALT write of 0x0008, busy=0, aborted=1, done=0.
- Entry0=0: WR_PL sends 1 and WR_PH sends 0; sequence completes.
- GO while busy: no restart, STEPCNT not cleared. GO+STOP in IDLE: stays IDLE.
- With `TIMER_SEQ_IRQ_EN`, IE=1: `irq` rises one cycle after done is set; a STATUS write drops it. Without the macro, `irq` stays 0 throughout.
